// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator advancing one pixel per pix_tick_i strobe.
// Outputs are decoded from the pre-increment counters and registered together, so they lag by one tick.
//   phase     | meaning
//   PH_ACTIVE | counter inside the visible area
//   PH_FP     | front porch
//   PH_SYNC   | sync pulse asserted
//   PH_BP     | back porch
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pix_tick_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FP     = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BP     = 2'd3;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [1:0] h_phase, v_phase;
  logic [9:0] x_q, y_q;
  logic       hsync_q, vsync_q, video_on_q;
  logic       line_start_q, frame_start_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    h_phase = PH_BP;
    if (h_cnt_q < H_ACT_END)       h_phase = PH_ACTIVE;
    else if (h_cnt_q < H_SYNC_BEG) h_phase = PH_FP;
    else if (h_cnt_q < H_SYNC_END) h_phase = PH_SYNC;
  end

  always_comb begin
    v_phase = PH_BP;
    if (v_cnt_q < V_ACT_END)       v_phase = PH_ACTIVE;
    else if (v_cnt_q < V_SYNC_BEG) v_phase = PH_FP;
    else if (v_cnt_q < V_SYNC_END) v_phase = PH_SYNC;
  end

  // Pulses clear on every clk so they stay one clk wide regardless of tick spacing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_tick_i) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        x_q           <= h_cnt_q;
        y_q           <= v_cnt_q;
        hsync_q       <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_q       <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_on_q    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        line_start_q  <= (h_cnt_q == '0);
        frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      end
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign video_on_o    = video_on_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size generator for line/hold/tied-high behaviour,
// a reduced-timing instance (15x9) for frame wrap, vsync and async reset.
module tb_vga_sync_gen;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       rst_a = 1'b1, pt_a = 1'b0;
  logic       hs_a, vs_a, vo_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       rst_s = 1'b1, pt_s = 1'b0;
  logic       hs_s, vs_s, vo_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  int n_cmp = 0;
  int n_bad = 0;
  int extra_a = 0, extra_s = 0;
  int hs_low_clk_a = 0;
  int clk_s = 0;

  vga_sync_gen u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .pix_tick_i(pt_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .video_on_o(vo_a),
    .x_o(x_a), .y_o(y_a), .line_start_o(ls_a), .frame_start_o(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) u_dut_s (
    .clk_i(clk), .rst_i(rst_s), .pix_tick_i(pt_s),
    .hsync_o(hs_s), .vsync_o(vs_s), .video_on_o(vo_s),
    .x_o(x_s), .y_o(y_s), .line_start_o(ls_s), .frame_start_o(fs_s)
  );

  // Expected {x, y, hsync, vsync, video_on, line_start, frame_start} after the k-th tick since reset.
  function automatic logic [24:0] exp_a(input int k);
    int h, v;
    h = k % 800;
    v = (k / 800) % 525;
    return {10'(h), 10'(v), !(h >= 656 && h < 752), !(v >= 490 && v < 492),
            (h < 640 && v < 480), (h == 0), (h == 0 && v == 0)};
  endfunction

  function automatic logic [24:0] exp_s(input int k);
    int h, v;
    h = k % 15;
    v = (k / 15) % 9;
    return {10'(h), 10'(v), !(h >= 10 && h < 13), !(v >= 5 && v < 7),
            (h < 8 && v < 4), (h == 0), (h == 0 && v == 0)};
  endfunction

  wire [24:0] obs_a = {x_a, y_a, hs_a, vs_a, vo_a, ls_a, fs_a};
  wire [24:0] obs_s = {x_s, y_s, hs_s, vs_s, vo_s, ls_s, fs_s};

  task automatic tick_a();
    pt_a = 1'b1;
    @(negedge clk);
    pt_a = 1'b0;
    if (!hs_a) hs_low_clk_a++;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ls_a || fs_a) extra_a++;
      if (!hs_a) hs_low_clk_a++;
    end
  endtask

  task automatic tick_s();
    pt_s = 1'b1;
    @(negedge clk);
    pt_s = 1'b0;
    clk_s++;
  endtask

  task automatic idle_s(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_s++;
      if (ls_s || fs_s) extra_s++;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    pt_a  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_a !== 25'h0000018) begin
      n_bad++;
      $display("FAIL reset_a_asserted got=%h exp=%h", obs_a, 25'h0000018);
    end
    rst_a = 1'b0;
    idle_a(3);
    n_cmp++;
    if (obs_a !== 25'h0000018) begin
      n_bad++;
      $display("FAIL reset_a_pre_tick got=%h exp=%h", obs_a, 25'h0000018);
    end
    tick_a();
    n_cmp++;
    if (obs_a !== exp_a(0)) begin
      n_bad++;
      $display("FAIL first_tick_a got=%h exp=%h", obs_a, exp_a(0));
    end
    idle_a(1);
    n_cmp++;
    if ({ls_a, fs_a} !== 2'b00) begin
      n_bad++;
      $display("FAIL first_pulse_width got=%b exp=00", {ls_a, fs_a});
    end
    idle_a(2);
  endtask

  task automatic test_line();
    extra_a = 0;
    hs_low_clk_a = 0;
    for (int k = 1; k <= 800; k++) begin
      tick_a();
      n_cmp++;
      if (obs_a !== exp_a(k)) begin
        n_bad++;
        $display("FAIL line_k%0d got=%h exp=%h", k, obs_a, exp_a(k));
      end
      idle_a(3);
    end
    n_cmp++;
    if (hs_low_clk_a !== 384) begin
      n_bad++;
      $display("FAIL hsync_low_clks got=%0d exp=384", hs_low_clk_a);
    end
    n_cmp++;
    if (extra_a !== 0) begin
      n_bad++;
      $display("FAIL line_extra_pulses got=%0d exp=0", extra_a);
    end
  endtask

  task automatic test_hold();
    int frozen_bad;
    frozen_bad = 0;
    extra_a = 0;
    for (int k = 801; k <= 1100; k++) begin
      tick_a();
      idle_a(3);
    end
    n_cmp++;
    if (obs_a !== {10'd300, 10'd1, 5'b11100}) begin
      n_bad++;
      $display("FAIL hold_reach_x300 got=%h exp=%h", obs_a, {10'd300, 10'd1, 5'b11100});
    end
    repeat (50) begin
      @(negedge clk);
      if (obs_a !== {10'd300, 10'd1, 5'b11100}) frozen_bad++;
    end
    n_cmp++;
    if (frozen_bad !== 0) begin
      n_bad++;
      $display("FAIL hold_frozen got=%0d_changed_clks exp=0", frozen_bad);
    end
    tick_a();
    n_cmp++;
    if (obs_a !== exp_a(1101)) begin
      n_bad++;
      $display("FAIL hold_resume got=%h exp=%h", obs_a, exp_a(1101));
    end
    idle_a(3);
  endtask

  task automatic test_back_to_back();
    int last_ls, periods;
    last_ls = -1;
    periods = 0;
    for (int k = 1102; k <= 2900; k++) begin
      tick_a();
      n_cmp++;
      if (obs_a !== exp_a(k)) begin
        n_bad++;
        $display("FAIL b2b_k%0d got=%h exp=%h", k, obs_a, exp_a(k));
      end
      if (ls_a) begin
        if (last_ls >= 0) begin
          periods++;
          n_cmp++;
          if (k - last_ls !== 800) begin
            n_bad++;
            $display("FAIL b2b_line_period got=%0d exp=800", k - last_ls);
          end
        end
        last_ls = k;
      end
    end
    pt_a = 1'b0;
    n_cmp++;
    if (periods !== 1) begin
      n_bad++;
      $display("FAIL b2b_line_count got=%0d exp=1", periods);
    end
  endtask

  task automatic reset_s();
    rst_s = 1'b1;
    pt_s  = 1'b0;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input bit tied_high);
    int last_fs, vs_low_ticks, exp_period, gap;
    last_fs = -1;
    vs_low_ticks = 0;
    extra_s = 0;
    clk_s = 0;
    gap = tied_high ? 0 : 3;
    exp_period = tied_high ? 135 : 540;
    reset_s();
    for (int k = 0; k <= 270; k++) begin
      tick_s();
      n_cmp++;
      if (obs_s !== exp_s(k)) begin
        n_bad++;
        $display("FAIL frame_th%0d_k%0d got=%h exp=%h", tied_high, k, obs_s, exp_s(k));
      end
      if (k < 135 && !vs_s) vs_low_ticks++;
      if (fs_s) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (clk_s - last_fs !== exp_period) begin
            n_bad++;
            $display("FAIL frame_period_th%0d got=%0d exp=%0d", tied_high, clk_s - last_fs, exp_period);
          end
        end
        last_fs = clk_s;
      end
      idle_s(gap);
    end
    pt_s = 1'b0;
    n_cmp++;
    if (vs_low_ticks !== 30) begin
      n_bad++;
      $display("FAIL vsync_low_ticks_th%0d got=%0d exp=30", tied_high, vs_low_ticks);
    end
    n_cmp++;
    if (extra_s !== 0) begin
      n_bad++;
      $display("FAIL frame_extra_pulses_th%0d got=%0d exp=0", tied_high, extra_s);
    end
  endtask

  task automatic test_async_reset();
    reset_s();
    for (int k = 0; k <= 101; k++) begin
      tick_s();
      if (k != 101) idle_s(3);
    end
    n_cmp++;
    if (obs_s !== {10'd11, 10'd6, 5'b00000}) begin
      n_bad++;
      $display("FAIL arst_setup got=%h exp=%h", obs_s, {10'd11, 10'd6, 5'b00000});
    end
    @(posedge clk);
    #2 rst_s = 1'b1;
    #1;
    n_cmp++;
    if (obs_s !== 25'h0000018) begin
      n_bad++;
      $display("FAIL arst_immediate got=%h exp=%h", obs_s, 25'h0000018);
    end
    @(negedge clk);
    rst_s = 1'b0;
    idle_s(3);
    n_cmp++;
    if (obs_s !== 25'h0000018) begin
      n_bad++;
      $display("FAIL arst_pre_tick got=%h exp=%h", obs_s, 25'h0000018);
    end
    tick_s();
    n_cmp++;
    if (obs_s !== exp_s(0)) begin
      n_bad++;
      $display("FAIL arst_first_tick got=%h exp=%h", obs_s, exp_s(0));
    end
    idle_s(1);
    n_cmp++;
    if ({ls_s, fs_s} !== 2'b00) begin
      n_bad++;
      $display("FAIL arst_pulse_width got=%b exp=00", {ls_s, fs_s});
    end
    tick_s();
    n_cmp++;
    if (obs_s !== exp_s(1)) begin
      n_bad++;
      $display("FAIL arst_second_tick got=%h exp=%h", obs_s, exp_s(1));
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_hold();
    test_back_to_back();
    test_frame(1'b0);
    test_frame(1'b1);
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
